// File: rtl/cs_pkg.sv
// Shared types for the chip-select decoder: region entry layout, reset-time region table,
// FSM state encoding and the cache-address bit mapping.
package cs_pkg;

    localparam int CS_CMPW = 12;

    typedef struct packed {
        logic [CS_CMPW-1:0] base;
        logic [CS_CMPW-1:0] mask;
        logic               cache;
        logic               en;
    } region_t;

    localparam region_t REGION0_DEFAULT = '{base: 12'h000, mask: 12'hC00, cache: 1'b1, en: 1'b1};
    localparam region_t REGION1_DEFAULT = '{base: 12'h400, mask: 12'hF00, cache: 1'b1, en: 1'b1};
    localparam region_t REGION2_DEFAULT = '{base: 12'h50F, mask: 12'hFFF, cache: 1'b1, en: 1'b1};
    localparam region_t REGION_OFF      = '{base: 12'h000, mask: 12'h000, cache: 1'b1, en: 1'b0};

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        HOLD
    } state_t;

    function automatic region_t region_default(input int idx);
        case (idx)
            0:       return REGION0_DEFAULT;
            1:       return REGION1_DEFAULT;
            2:       return REGION2_DEFAULT;
            default: return REGION_OFF;
        endcase
    endfunction

    // Cache space folds A30/A28 onto the top two bits and drops the byte-lane bits.
    function automatic logic [27:0] ca_map(input logic [31:0] a);
        return {a[30], a[28], a[25:2], 2'b00};
    endfunction

endpackage

// File: rtl/cs_region_match.sv
// Single-region address comparator: masked compare of the upper address bits against one
// region's base, qualified by the region enable. Purely combinational.
module cs_region_match
    import cs_pkg::*;
(
    input  logic [CS_CMPW-1:0] tag,
    input  region_t            rgn,
    output logic               hit
);

    assign hit = rgn.en && (((tag ^ rgn.base) & rgn.mask) == '0);

endmodule

// File: rtl/cs_decode_pipe.sv
// Registered, programmable chip-select decoder for the 68030 bus; outputs held for the bus cycle.
// Build option: define LOMEM_CACHE_EN to add the low-memory cache select comparator.
//
// state  | meaning
// IDLE   | waiting for nAS; pending table writes are applied here
// DECODE | address latched, table compared, outputs registered on exit
// HOLD   | outputs held until nAS is released
module cs_decode_pipe
    import cs_pkg::*;
#(
    parameter int NREG = 4,
    parameter int CMPW = CS_CMPW,
    parameter int SELW = $clog2(NREG)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [31:0]      A,
    input  logic             nAS,
    output logic             Valid,
    output logic [NREG-1:0]  CS,
    output logic             CacheCS,
    output logic             LoMemCacheCS,
    output logic [27:0]      CA,
    input  logic             CfgWr,
    input  logic [SELW-1:0]  CfgSel,
    input  logic [CMPW-1:0]  CfgBase,
    input  logic [CMPW-1:0]  CfgMask,
    input  logic             CfgCache,
    input  logic             CfgEn,
    output logic             CfgBusy
);

    state_t            state_q, state_d;
    logic              capture, load, drop;
    logic [31:2]       areg;
    logic [CMPW-1:0]   tag;
    region_t           tbl [NREG];
    logic [NREG-1:0]   hit;
    logic [NREG-1:0]   win_cs;
    logic              win_cache, found;
    logic              valid_q, cache_q;
    logic [NREG-1:0]   cs_q;
    logic [27:0]       ca_q;
    logic              pend_q;
    logic [SELW-1:0]   pend_sel;
    region_t           pend_rgn;
    logic              sel_ok, apply_ok, wr_en;
    logic [SELW-1:0]   wr_sel;
    region_t           cfg_rgn, wr_rgn;
    logic              unused_a;

    assign unused_a = ^A[1:0];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        load    = 1'b0;
        drop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!nAS) begin
                    capture = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (nAS) begin
                    state_d = IDLE;
                end else begin
                    load    = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (nAS) begin
                    drop    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tag = areg[31 -: CMPW];

    for (genvar g = 0; g < NREG; g++) begin : g_match
        cs_region_match u_match (
            .tag (tag),
            .rgn (tbl[g]),
            .hit (hit[g])
        );
    end

    always_comb begin
        win_cs    = '0;
        win_cache = 1'b0;
        found     = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (hit[i] && !found) begin
                found     = 1'b1;
                win_cs[i] = 1'b1;
                win_cache = tbl[i].cache;
            end
        end
    end

    // CA keeps its last value through IDLE and aborted cycles; only reset clears it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            areg    <= '0;
            valid_q <= 1'b0;
            cs_q    <= '0;
            cache_q <= 1'b0;
            ca_q    <= '0;
        end else begin
            if (capture) areg <= A[31:2];
            if (load) begin
                valid_q <= 1'b1;
                cs_q    <= win_cs;
                cache_q <= win_cache;
                ca_q    <= ca_map({areg, 2'b00});
            end else if (drop) begin
                valid_q <= 1'b0;
                cs_q    <= '0;
                cache_q <= 1'b0;
            end
        end
    end

`ifdef LOMEM_CACHE_EN
    logic lomem_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)       lomem_q <= 1'b0;
        else if (load) lomem_q <= hit[0] && (areg[25:12] == 14'd0);
        else if (drop) lomem_q <= 1'b0;
    end

    assign LoMemCacheCS = lomem_q;
`else
    assign LoMemCacheCS = 1'b0;
`endif

    // Table writes land only in IDLE without a capture, so the table is frozen across a bus cycle.
    always_comb begin
        sel_ok = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (CfgSel == SELW'(i)) sel_ok = 1'b1;
        end
        cfg_rgn.base  = CfgBase;
        cfg_rgn.mask  = CfgMask;
        cfg_rgn.cache = CfgCache;
        cfg_rgn.en    = CfgEn;
        apply_ok = (state_q == IDLE) && nAS;
        wr_en    = 1'b0;
        wr_sel   = pend_sel;
        wr_rgn   = pend_rgn;
        if (apply_ok) begin
            if (CfgWr && sel_ok) begin
                wr_en  = 1'b1;
                wr_sel = CfgSel;
                wr_rgn = cfg_rgn;
            end else if (pend_q) begin
                wr_en = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend_q   <= 1'b0;
            pend_sel <= '0;
            pend_rgn <= '0;
        end else if (apply_ok) begin
            pend_q <= 1'b0;
        end else if (CfgWr && sel_ok) begin
            pend_q   <= 1'b1;
            pend_sel <= CfgSel;
            pend_rgn <= cfg_rgn;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NREG; i++) tbl[i] <= region_default(i);
        end else if (wr_en) begin
            for (int i = 0; i < NREG; i++) begin
                if (wr_sel == SELW'(i)) tbl[i] <= wr_rgn;
            end
        end
    end

    assign Valid   = valid_q;
    assign CS      = cs_q;
    assign CacheCS = cache_q;
    assign CA      = ca_q;
    assign CfgBusy = pend_q;

endmodule

// File: tb/tb_cs_decode_pipe.sv
// Bench for cs_decode_pipe: scoreboarded bus cycles, aborted cycles, runtime table writes
// and asynchronous reset in the middle of a cycle.
`timescale 1ns/1ps
module tb_cs_decode_pipe;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] A;
    logic        nAS;
    logic        Valid;
    logic [3:0]  CS;
    logic        CacheCS;
    logic        LoMemCacheCS;
    logic [27:0] CA;
    logic        CfgWr;
    logic [1:0]  CfgSel;
    logic [11:0] CfgBase;
    logic [11:0] CfgMask;
    logic        CfgCache;
    logic        CfgEn;
    logic        CfgBusy;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef LOMEM_CACHE_EN
    localparam bit LM = 1'b1;
`else
    localparam bit LM = 1'b0;
`endif

    typedef struct {
        logic [3:0]  cs;
        logic        cache;
        logic        lomem;
        logic [27:0] ca;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        exp_t        e;
    } vec_t;

    exp_t sb[$];

    cs_decode_pipe dut (
        .CLK          (CLK),
        .RST          (RST),
        .A            (A),
        .nAS          (nAS),
        .Valid        (Valid),
        .CS           (CS),
        .CacheCS      (CacheCS),
        .LoMemCacheCS (LoMemCacheCS),
        .CA           (CA),
        .CfgWr        (CfgWr),
        .CfgSel       (CfgSel),
        .CfgBase      (CfgBase),
        .CfgMask      (CfgMask),
        .CfgCache     (CfgCache),
        .CfgEn        (CfgEn),
        .CfgBusy      (CfgBusy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input logic [3:0] cs, input logic cache, input logic lomem,
                                input logic [27:0] ca);
        exp_t e;
        e.cs = cs; e.cache = cache; e.lomem = lomem; e.ca = ca;
        return e;
    endfunction

    // lat = negedges from nAS drive to Valid; 0 when Valid never came.
    task automatic start_cycle(input logic [31:0] addr, input bit sync, output int lat);
        if (sync) @(negedge CLK);
        A   = addr;
        nAS = 1'b0;
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge CLK);
            if (Valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        A = 32'hDEAD_BEEF;
    endtask

    task automatic end_cycle();
        nAS = 1'b1;
        @(negedge CLK);
    endtask

    task automatic cfg_drive(input logic [1:0] sel, input logic [11:0] base, input logic [11:0] mask,
                             input logic cache, input logic en);
        CfgWr = 1'b1; CfgSel = sel; CfgBase = base; CfgMask = mask; CfgCache = cache; CfgEn = en;
    endtask

    task automatic test_reset();
        RST = 1'b1; nAS = 1'b1; A = '0;
        CfgWr = 1'b0; CfgSel = '0; CfgBase = '0; CfgMask = '0; CfgCache = 1'b0; CfgEn = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        n_checks++; if ({Valid, CS, CacheCS, LoMemCacheCS} !== 7'd0) $display("FAIL reset_sel got %b want 0", {Valid, CS, CacheCS, LoMemCacheCS}); else n_pass++;
        n_checks++; if (CA !== 28'd0) $display("FAIL reset_ca got %h want 0", CA); else n_pass++;
        n_checks++; if (CfgBusy !== 1'b0) $display("FAIL reset_busy got %b want 0", CfgBusy); else n_pass++;
    endtask

    task automatic test_decode();
        vec_t v[$];
        exp_t e;
        int   lat;
        v.push_back('{32'h0000_1000, mk(4'b0001, 1'b1, 1'b0, 28'h000_1000)});
        v.push_back('{32'h0000_0800, mk(4'b0001, 1'b1, LM,   28'h000_0800)});
        v.push_back('{32'h50F0_0004, mk(4'b0100, 1'b1, 1'b0, 28'hCF0_0004)});
        v.push_back('{32'h4012_3458, mk(4'b0010, 1'b1, 1'b0, 28'h812_3458)});
        v.push_back('{32'h6000_0000, mk(4'b0000, 1'b0, 1'b0, 28'h800_0000)});
        v.push_back('{32'h3FFF_F000, mk(4'b0001, 1'b1, 1'b0, 28'h7FF_F000)});
        v.push_back('{32'h4FF0_0000, mk(4'b0010, 1'b1, 1'b0, 28'hBF0_0000)});
        v.push_back('{32'h50E0_0000, mk(4'b0000, 1'b0, 1'b0, 28'hCE0_0000)});
        foreach (v[i]) begin
            sb.push_back(v[i].e);
            start_cycle(v[i].addr, 1'b1, lat);
            e = sb.pop_front();
            n_checks++; if (lat !== 2) $display("FAIL dec_latency a=%h got %0d want 2", v[i].addr, lat); else n_pass++;
            n_checks++; if (CS !== e.cs) $display("FAIL dec_cs a=%h got %b want %b", v[i].addr, CS, e.cs); else n_pass++;
            n_checks++; if (CacheCS !== e.cache) $display("FAIL dec_cache a=%h got %b want %b", v[i].addr, CacheCS, e.cache); else n_pass++;
            n_checks++; if (LoMemCacheCS !== e.lomem) $display("FAIL dec_lomem a=%h got %b want %b", v[i].addr, LoMemCacheCS, e.lomem); else n_pass++;
            n_checks++; if (CA !== e.ca) $display("FAIL dec_ca a=%h got %h want %h", v[i].addr, CA, e.ca); else n_pass++;
            @(negedge CLK);
            n_checks++; if ({Valid, CS, CA} !== {1'b1, e.cs, e.ca}) $display("FAIL dec_hold a=%h got %b/%b/%h want 1/%b/%h", v[i].addr, Valid, CS, CA, e.cs, e.ca); else n_pass++;
            end_cycle();
            n_checks++; if ({Valid, CS, CacheCS, LoMemCacheCS} !== 7'd0) $display("FAIL dec_clear a=%h got %b want 0", v[i].addr, {Valid, CS, CacheCS, LoMemCacheCS}); else n_pass++;
            n_checks++; if (CA !== e.ca) $display("FAIL dec_ca_idle a=%h got %h want %h", v[i].addr, CA, e.ca); else n_pass++;
        end
    endtask

    task automatic test_abort();
        logic [27:0] prev_ca;
        bit          seen;
        exp_t        e;
        int          lat;
        prev_ca = CA;
        @(negedge CLK);
        A = 32'h0000_1000; nAS = 1'b0;
        @(negedge CLK);
        nAS = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            if (Valid !== 1'b0 || CS !== 4'd0) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL abort_valid got asserted want never"); else n_pass++;
        n_checks++; if (CA !== prev_ca) $display("FAIL abort_ca got %h want %h", CA, prev_ca); else n_pass++;
        sb.push_back(mk(4'b0010, 1'b1, 1'b0, 28'h812_3458));
        start_cycle(32'h4012_3458, 1'b1, lat);
        e = sb.pop_front();
        n_checks++; if (lat !== 2) $display("FAIL abort_next_latency got %0d want 2", lat); else n_pass++;
        n_checks++; if ({CS, CA} !== {e.cs, e.ca}) $display("FAIL abort_next got %b/%h want %b/%h", CS, CA, e.cs, e.ca); else n_pass++;
        end_cycle();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat;
        sb.push_back(mk(4'b0100, 1'b1, 1'b0, 28'hCF0_0004));
        start_cycle(32'h50F0_0004, 1'b1, lat);
        e = sb.pop_front();
        n_checks++; if (CS !== e.cs) $display("FAIL b2b_first_cs got %b want %b", CS, e.cs); else n_pass++;
        end_cycle();
        sb.push_back(mk(4'b0001, 1'b1, LM, 28'h000_0800));
        start_cycle(32'h0000_0800, 1'b0, lat);
        e = sb.pop_front();
        n_checks++; if (lat !== 2) $display("FAIL b2b_latency got %0d want 2", lat); else n_pass++;
        n_checks++; if ({CS, LoMemCacheCS, CA} !== {e.cs, e.lomem, e.ca}) $display("FAIL b2b_second got %b/%b/%h want %b/%b/%h", CS, LoMemCacheCS, CA, e.cs, e.lomem, e.ca); else n_pass++;
        end_cycle();
    endtask

    task automatic test_cfg_idle();
        exp_t e;
        int   lat;
        @(negedge CLK);
        cfg_drive(2'd1, 12'h400, 12'hF00, 1'b0, 1'b1);
        @(negedge CLK);
        CfgWr = 1'b0;
        n_checks++; if (CfgBusy !== 1'b0) $display("FAIL cfg_idle_busy got %b want 0", CfgBusy); else n_pass++;
        sb.push_back(mk(4'b0010, 1'b0, 1'b0, 28'h812_3458));
        start_cycle(32'h4012_3458, 1'b1, lat);
        e = sb.pop_front();
        n_checks++; if ({CS, CacheCS} !== {e.cs, e.cache}) $display("FAIL cfg_idle_decode got %b/%b want %b/%b", CS, CacheCS, e.cs, e.cache); else n_pass++;
        end_cycle();
    endtask

    task automatic test_cfg_capture();
        exp_t e;
        int   lat;
        @(negedge CLK);
        A = 32'h0000_1000; nAS = 1'b0;
        cfg_drive(2'd0, 12'h000, 12'hC00, 1'b1, 1'b0);
        @(negedge CLK);
        CfgWr = 1'b0;
        n_checks++; if (CfgBusy !== 1'b1) $display("FAIL cap_busy got %b want 1", CfgBusy); else n_pass++;
        @(negedge CLK);
        n_checks++; if ({Valid, CS} !== 5'b1_0001) $display("FAIL cap_old_table got %b want 10001", {Valid, CS}); else n_pass++;
        end_cycle();
        n_checks++; if (CfgBusy !== 1'b1) $display("FAIL cap_busy_exit got %b want 1", CfgBusy); else n_pass++;
        @(negedge CLK);
        n_checks++; if (CfgBusy !== 1'b0) $display("FAIL cap_busy_idle got %b want 0", CfgBusy); else n_pass++;
        sb.push_back(mk(4'b0000, 1'b0, 1'b0, 28'h000_1000));
        start_cycle(32'h0000_1000, 1'b1, lat);
        e = sb.pop_front();
        n_checks++; if ({Valid, CS, CacheCS} !== {1'b1, e.cs, e.cache}) $display("FAIL cap_new_table got %b want %b", {Valid, CS, CacheCS}, {1'b1, e.cs, e.cache}); else n_pass++;
        end_cycle();
    endtask

    task automatic test_cfg_hold();
        exp_t e;
        int   lat;
        start_cycle(32'h4012_3458, 1'b1, lat);
        cfg_drive(2'd3, 12'h600, 12'hF00, 1'b0, 1'b1);
        @(negedge CLK);
        CfgWr = 1'b0;
        n_checks++; if (CfgBusy !== 1'b1) $display("FAIL hold_busy got %b want 1", CfgBusy); else n_pass++;
        n_checks++; if ({Valid, CS} !== 5'b1_0010) $display("FAIL hold_outputs got %b want 10010", {Valid, CS}); else n_pass++;
        end_cycle();
        n_checks++; if (CfgBusy !== 1'b1) $display("FAIL hold_busy_exit got %b want 1", CfgBusy); else n_pass++;
        @(negedge CLK);
        n_checks++; if (CfgBusy !== 1'b0) $display("FAIL hold_busy_idle got %b want 0", CfgBusy); else n_pass++;
        sb.push_back(mk(4'b1000, 1'b0, 1'b0, 28'h800_0000));
        start_cycle(32'h6000_0000, 1'b1, lat);
        e = sb.pop_front();
        n_checks++; if ({CS, CacheCS, CA} !== {e.cs, e.cache, e.ca}) $display("FAIL hold_region3 got %b/%b/%h want %b/%b/%h", CS, CacheCS, CA, e.cs, e.cache, e.ca); else n_pass++;
        end_cycle();
    endtask

    task automatic test_reset_midcycle();
        vec_t v[$];
        exp_t e;
        int   lat;
        sb.push_back(mk(4'b1000, 1'b0, 1'b0, 28'h800_0000));
        start_cycle(32'h6000_0000, 1'b1, lat);
        e = sb.pop_front();
        n_checks++; if (CS !== e.cs) $display("FAIL rst_pre_cs got %b want %b", CS, e.cs); else n_pass++;
        cfg_drive(2'd2, 12'h123, 12'hFFF, 1'b1, 1'b1);
        @(negedge CLK);
        CfgWr = 1'b0;
        n_checks++; if (CfgBusy !== 1'b1) $display("FAIL rst_pre_busy got %b want 1", CfgBusy); else n_pass++;
        #2 RST = 1'b1;
        #1;
        n_checks++; if ({Valid, CS, CacheCS, LoMemCacheCS} !== 7'd0) $display("FAIL rst_async_sel got %b want 0", {Valid, CS, CacheCS, LoMemCacheCS}); else n_pass++;
        n_checks++; if (CA !== 28'd0) $display("FAIL rst_async_ca got %h want 0", CA); else n_pass++;
        n_checks++; if (CfgBusy !== 1'b0) $display("FAIL rst_async_busy got %b want 0", CfgBusy); else n_pass++;
        nAS = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        v.push_back('{32'h6000_0000, mk(4'b0000, 1'b0, 1'b0, 28'h800_0000)});
        v.push_back('{32'h50F0_0004, mk(4'b0100, 1'b1, 1'b0, 28'hCF0_0004)});
        v.push_back('{32'h0000_1000, mk(4'b0001, 1'b1, 1'b0, 28'h000_1000)});
        v.push_back('{32'h4012_3458, mk(4'b0010, 1'b1, 1'b0, 28'h812_3458)});
        foreach (v[i]) begin
            sb.push_back(v[i].e);
            start_cycle(v[i].addr, 1'b1, lat);
            e = sb.pop_front();
            n_checks++; if ({Valid, CS, CacheCS} !== {1'b1, e.cs, e.cache}) $display("FAIL rst_post a=%h got %b want %b", v[i].addr, {Valid, CS, CacheCS}, {1'b1, e.cs, e.cache}); else n_pass++;
            end_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_abort();
        test_back_to_back();
        test_cfg_idle();
        test_cfg_capture();
        test_cfg_hold();
        test_reset_midcycle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
